// File: rtl/mmio_map_pkg.sv
// Register map and status-bit layout shared by the MMIO peripheral unit and its FIFO.
// Byte addresses are word-aligned; anything else decodes as unmapped.
package mmio_map_pkg;

    localparam logic [7:0] ADDR_LED      = 8'h00;
    localparam logic [7:0] ADDR_IN_STAT  = 8'h04;
    localparam logic [7:0] ADDR_SEG      = 8'h08;
    localparam logic [7:0] ADDR_IN_DATA  = 8'h0C;
    localparam logic [7:0] ADDR_OUT_STAT = 8'h10;
    localparam logic [7:0] ADDR_CYCLE    = 8'h14;

    localparam int IN_STAT_NONEMPTY_BIT = 0;
    localparam int IN_STAT_COUNT_LSB    = 4;
    localparam int IN_STAT_COUNT_W      = 4;
    localparam int OUT_STAT_IDLE_BIT    = 0;
    localparam int OUT_STAT_DROP_BIT    = 1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_IN_STAT,
        REG_SEG,
        REG_IN_DATA,
        REG_OUT_STAT,
        REG_CYCLE
    } reg_sel_e;

endpackage

// File: rtl/mmio_periph_unit_if.sv
// CPU IO bus plus LED/segment/switch handshake signals of the MMIO peripheral unit.
// The master side is the CPU/board environment, the slave side is the peripheral.
interface mmio_periph_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] io_addr;
    logic [31:0]       io_dout;
    logic              io_we;
    logic              io_rd;
    logic [31:0]       io_din;
    logic [31:0]       led;
    logic [31:0]       seg_data;
    logic              seg_valid;
    logic              seg_ready;
    logic [31:0]       sw_data;
    logic              sw_valid;
    logic              sw_ready;

    modport master (
        output io_addr, io_dout, io_we, io_rd, seg_ready, sw_data, sw_valid,
        input  io_din, led, seg_data, seg_valid, sw_ready
    );

    modport slave (
        input  io_addr, io_dout, io_we, io_rd, seg_ready, sw_data, sw_valid,
        output io_din, led, seg_data, seg_valid, sw_ready
    );
endinterface

// File: rtl/mmio_in_fifo.sv
// Synchronous FIFO for switch input words with a combinational head output (0 when empty).
// Push when full and pop when empty are ignored; pointers wrap modulo DEPTH.
module mmio_in_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [31:0]              push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage carries no reset; validity is tracked by count/pointers alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/mmio_periph_unit.sv
// Memory-mapped LED/segment/switch peripheral on the CPU IO bus with same-cycle read data.
// Define MMIO_CYCLE_CNT_EN to build the free-running cycle counter at 0x14.
module mmio_periph_unit
    import mmio_map_pkg::*;
#(
    parameter int IN_DEPTH = 4,
    parameter int ADDR_W   = 8
) (
    input logic               clk,
    input logic               rst,
    mmio_periph_unit_if.slave bus
);
    localparam int CNT_W = $clog2(IN_DEPTH) + 1;

    reg_sel_e         sel;
    logic [31:0]      led_q, led_d;
    logic [31:0]      seg_data_q, seg_data_d;
    logic             seg_valid_q, seg_valid_d;
    logic             drop_q, drop_d;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      fifo_head;
    logic [31:0]      cycle_rd;

    always_comb begin
        sel = REG_NONE;
        if (bus.io_addr == ADDR_W'(ADDR_LED))           sel = REG_LED;
        else if (bus.io_addr == ADDR_W'(ADDR_IN_STAT))  sel = REG_IN_STAT;
        else if (bus.io_addr == ADDR_W'(ADDR_SEG))      sel = REG_SEG;
        else if (bus.io_addr == ADDR_W'(ADDR_IN_DATA))  sel = REG_IN_DATA;
        else if (bus.io_addr == ADDR_W'(ADDR_OUT_STAT)) sel = REG_OUT_STAT;
        else if (bus.io_addr == ADDR_W'(ADDR_CYCLE))    sel = REG_CYCLE;
    end

    assign fifo_pop = bus.io_rd & (sel == REG_IN_DATA);

    mmio_in_fifo #(
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.sw_valid),
        .push_data (bus.sw_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // sw_ready comes from registered count only, so a same-cycle pop never raises it.
    assign bus.sw_ready = ~fifo_full;

    always_comb begin
        led_d       = led_q;
        seg_data_d  = seg_data_q;
        seg_valid_d = seg_valid_q;
        drop_d      = drop_q;
        if (bus.io_we && sel == REG_LED) begin
            led_d = bus.io_dout;
        end
        // A write while the display is stalled is lost; one landing on the accept edge reloads.
        if (bus.io_we && sel == REG_SEG) begin
            if (seg_valid_q && !bus.seg_ready) begin
                drop_d = 1'b1;
            end else begin
                seg_data_d  = bus.io_dout;
                seg_valid_d = 1'b1;
            end
        end else if (seg_valid_q && bus.seg_ready) begin
            seg_valid_d = 1'b0;
        end
        if (bus.io_rd && sel == REG_OUT_STAT) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q       <= '0;
            seg_data_q  <= '0;
            seg_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            led_q       <= led_d;
            seg_data_q  <= seg_data_d;
            seg_valid_q <= seg_valid_d;
            drop_q      <= drop_d;
        end
    end

`ifdef MMIO_CYCLE_CNT_EN
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (bus.io_we && sel == REG_CYCLE) begin
            cycle_d = bus.io_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = '0;
`endif

    // Read data is not gated by io_rd so a load completes in the same cycle.
    always_comb begin
        bus.io_din = '0;
        case (sel)
            REG_IN_STAT: begin
                bus.io_din[IN_STAT_NONEMPTY_BIT] = ~fifo_empty;
                bus.io_din[IN_STAT_COUNT_LSB +: IN_STAT_COUNT_W] = IN_STAT_COUNT_W'(fifo_count);
            end
            REG_IN_DATA: bus.io_din = fifo_head;
            REG_OUT_STAT: begin
                bus.io_din[OUT_STAT_IDLE_BIT] = ~seg_valid_q;
                bus.io_din[OUT_STAT_DROP_BIT] = drop_q;
            end
            REG_CYCLE: bus.io_din = cycle_rd;
            default: bus.io_din = '0;
        endcase
    end

    assign bus.led       = led_q;
    assign bus.seg_data  = seg_data_q;
    assign bus.seg_valid = seg_valid_q;
endmodule

// File: tb/tb_mmio_periph_unit.sv
// Bench for mmio_periph_unit: directed vector table, hand sequences, then random traffic
// checked against a queue-based reference model of the register map.
module tb_mmio_periph_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_periph_unit_if #(.ADDR_W(8)) bus ();

    mmio_periph_unit #(
        .IN_DEPTH (DEPTH),
        .ADDR_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        we;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] dout;
        logic        seg_ready;
        logic        sw_valid;
        logic [31:0] sw_data;
        logic [31:0] exp_din;
        logic [31:0] exp_led;
        logic [31:0] exp_seg;
        logic        exp_sv;
        logic        exp_swr;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] m_led, m_seg, m_cyc;
    logic        m_sv, m_drop;
    logic [31:0] m_q[$];

    function automatic vec_t mk(input logic we, rd, input logic [7:0] addr,
                                input logic [31:0] dout, input logic seg_ready, sw_valid,
                                input logic [31:0] sw_data, exp_din, exp_led, exp_seg,
                                input logic exp_sv, exp_swr);
        vec_t v;
        v.we = we; v.rd = rd; v.addr = addr; v.dout = dout;
        v.seg_ready = seg_ready; v.sw_valid = sw_valid; v.sw_data = sw_data;
        v.exp_din = exp_din; v.exp_led = exp_led; v.exp_seg = exp_seg;
        v.exp_sv = exp_sv; v.exp_swr = exp_swr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.io_we = 1'b0; bus.io_rd = 1'b0; bus.io_addr = 8'h00; bus.io_dout = '0;
        bus.seg_ready = 1'b0; bus.sw_valid = 1'b0; bus.sw_data = '0;
    endtask

    task automatic rd_check(input logic [7:0] a, input logic [31:0] exp, input string name);
        bus.io_we = 1'b0; bus.io_rd = 1'b0; bus.io_addr = a;
        #1;
        chk(name, bus.io_din, exp);
    endtask

    function automatic logic [31:0] model_din(input logic [7:0] a);
        case (a)
            8'h04: return {24'd0, 4'(m_q.size()), 3'd0, m_q.size() != 0};
            8'h0C: return (m_q.size() != 0) ? m_q[0] : 32'd0;
            8'h10: return {30'd0, m_drop, ~m_sv};
`ifdef MMIO_CYCLE_CNT_EN
            8'h14: return m_cyc;
`endif
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        logic [7:0] addr_tbl [9];
        logic [31:0] exp_cnt_a, exp_cnt_b, exp_cnt_c;
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_led", bus.led, 32'h0);
        chk("reset_seg_valid", bus.seg_valid, 32'h0);
        chk("reset_sw_ready", bus.sw_ready, 32'h1);

        //          we rd addr   dout       srdy swv sw_data  din        led        seg       sv swr
        vecs.push_back(mk(0, 0, 8'h10, 32'h0,     0, 0, 32'h0,  32'h1,     32'h0,     32'h0,    0, 1));
        vecs.push_back(mk(1, 0, 8'h00, 32'hA5A5,  0, 0, 32'h0,  32'h0,     32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(0, 1, 8'h10, 32'h0,     0, 0, 32'h0,  32'h1,     32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(0, 0, 8'h04, 32'h0,     0, 1, 32'h11, 32'h0,     32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(0, 0, 8'h04, 32'h0,     0, 1, 32'h22, 32'h11,    32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(0, 0, 8'h04, 32'h0,     0, 1, 32'h33, 32'h21,    32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(0, 0, 8'h04, 32'h0,     0, 1, 32'h44, 32'h31,    32'hA5A5,  32'h0,    0, 0));
        vecs.push_back(mk(0, 0, 8'h04, 32'h0,     0, 1, 32'h55, 32'h41,    32'hA5A5,  32'h0,    0, 0));
        vecs.push_back(mk(0, 1, 8'h0C, 32'h0,     0, 0, 32'h0,  32'h11,    32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(0, 1, 8'h0C, 32'h0,     0, 0, 32'h0,  32'h22,    32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(0, 1, 8'h0C, 32'h0,     0, 0, 32'h0,  32'h33,    32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(0, 1, 8'h0C, 32'h0,     0, 0, 32'h0,  32'h44,    32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(0, 1, 8'h0C, 32'h0,     0, 0, 32'h0,  32'h0,     32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(0, 0, 8'h04, 32'h0,     0, 0, 32'h0,  32'h0,     32'hA5A5,  32'h0,    0, 1));
        vecs.push_back(mk(1, 0, 8'h08, 32'hDEAD,  0, 0, 32'h0,  32'h0,     32'hA5A5,  32'hDEAD, 1, 1));
        vecs.push_back(mk(1, 0, 8'h08, 32'hBEEF,  0, 0, 32'h0,  32'h0,     32'hA5A5,  32'hDEAD, 1, 1));
        vecs.push_back(mk(0, 1, 8'h10, 32'h0,     0, 0, 32'h0,  32'h2,     32'hA5A5,  32'hDEAD, 1, 1));
        vecs.push_back(mk(0, 1, 8'h10, 32'h0,     0, 0, 32'h0,  32'h0,     32'hA5A5,  32'hDEAD, 1, 1));
        vecs.push_back(mk(0, 0, 8'h10, 32'h0,     1, 0, 32'h0,  32'h0,     32'hA5A5,  32'hDEAD, 0, 1));
        vecs.push_back(mk(0, 0, 8'h10, 32'h0,     0, 0, 32'h0,  32'h1,     32'hA5A5,  32'hDEAD, 0, 1));
        vecs.push_back(mk(1, 0, 8'h08, 32'h5555,  0, 0, 32'h0,  32'h0,     32'hA5A5,  32'h5555, 1, 1));
        vecs.push_back(mk(1, 0, 8'h08, 32'h1234,  1, 0, 32'h0,  32'h0,     32'hA5A5,  32'h1234, 1, 1));
        vecs.push_back(mk(0, 0, 8'h10, 32'h0,     0, 0, 32'h0,  32'h0,     32'hA5A5,  32'h1234, 1, 1));
        vecs.push_back(mk(0, 0, 8'h10, 32'h0,     1, 0, 32'h0,  32'h0,     32'hA5A5,  32'h1234, 0, 1));
        vecs.push_back(mk(1, 0, 8'h18, 32'hFFFF,  0, 0, 32'h0,  32'h0,     32'hA5A5,  32'h1234, 0, 1));
        vecs.push_back(mk(1, 0, 8'h01, 32'h1,     0, 0, 32'h0,  32'h0,     32'hA5A5,  32'h1234, 0, 1));
        vecs.push_back(mk(1, 1, 8'h00, 32'h77,    0, 0, 32'h0,  32'h0,     32'h77,    32'h1234, 0, 1));

        foreach (vecs[i]) begin
            bus.io_we = vecs[i].we; bus.io_rd = vecs[i].rd; bus.io_addr = vecs[i].addr;
            bus.io_dout = vecs[i].dout; bus.seg_ready = vecs[i].seg_ready;
            bus.sw_valid = vecs[i].sw_valid; bus.sw_data = vecs[i].sw_data;
            #1;
            chk($sformatf("v%0d_din", i), bus.io_din, vecs[i].exp_din);
            cycle();
            chk($sformatf("v%0d_led", i), bus.led, vecs[i].exp_led);
            chk($sformatf("v%0d_seg_data", i), bus.seg_data, vecs[i].exp_seg);
            chk($sformatf("v%0d_seg_valid", i), bus.seg_valid, 32'(vecs[i].exp_sv));
            chk($sformatf("v%0d_sw_ready", i), bus.sw_ready, 32'(vecs[i].exp_swr));
        end

        // Pop while full with sw_valid high: push refused this cycle, space visible next cycle
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.sw_valid = 1'b1;
            bus.sw_data  = 32'(32'hA0 + i);
            cycle();
        end
        bus.sw_data = 32'h99; bus.io_rd = 1'b1; bus.io_addr = 8'h0C;
        #1;
        chk("t4_sw_ready_full", bus.sw_ready, 32'h0);
        chk("t4_head", bus.io_din, 32'hA0);
        cycle();
        idle();
        chk("t4_sw_ready_after", bus.sw_ready, 32'h1);
        rd_check(8'h04, 32'h31, "t4_count3");
        for (int i = 1; i < 4; i++) begin
            bus.io_rd = 1'b1; bus.io_addr = 8'h0C;
            #1;
            chk($sformatf("t4_drain%0d", i), bus.io_din, 32'(32'hA0 + i));
            cycle();
        end
        rd_check(8'h0C, 32'h0, "t4_empty_data");
        rd_check(8'h04, 32'h0, "t4_empty_stat");

        // Reset mid-transfer drops FIFO contents and pending segment word
        idle();
        bus.sw_valid = 1'b1; bus.sw_data = 32'h5;
        cycle();
        cycle();
        idle();
        bus.io_we = 1'b1; bus.io_addr = 8'h08; bus.io_dout = 32'hCAFE;
        cycle();
        idle();
        chk("rst_pre_seg_valid", bus.seg_valid, 32'h1);
        rd_check(8'h04, 32'h21, "rst_pre_count");
        rst = 1'b1; bus.sw_valid = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        chk("rst_sw_ready", bus.sw_ready, 32'h1);
        chk("rst_seg_valid", bus.seg_valid, 32'h0);
        chk("rst_seg_data", bus.seg_data, 32'h0);
        chk("rst_led", bus.led, 32'h0);
        rd_check(8'h04, 32'h0, "rst_in_stat");
        rd_check(8'h10, 32'h1, "rst_out_stat");

        // Cycle counter
`ifdef MMIO_CYCLE_CNT_EN
        exp_cnt_a = 32'd10; exp_cnt_b = 32'hFFFF_FFFF; exp_cnt_c = 32'd0;
`else
        exp_cnt_a = 32'd0;  exp_cnt_b = 32'd0;         exp_cnt_c = 32'd0;
`endif
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        bus.io_addr = 8'h14;
        repeat (10) cycle();
        chk("cnt_after_10", bus.io_din, exp_cnt_a);
        bus.io_we = 1'b1; bus.io_dout = 32'hFFFF_FFFF;
        cycle();
        bus.io_we = 1'b0;
        #1;
        chk("cnt_loaded", bus.io_din, exp_cnt_b);
        cycle();
        chk("cnt_wrapped", bus.io_din, exp_cnt_c);

        // Random traffic against the reference model
        addr_tbl[0] = 8'h00; addr_tbl[1] = 8'h04; addr_tbl[2] = 8'h08;
        addr_tbl[3] = 8'h0C; addr_tbl[4] = 8'h10; addr_tbl[5] = 8'h14;
        addr_tbl[6] = 8'h18; addr_tbl[7] = 8'h0C; addr_tbl[8] = 8'h00;
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        m_led = '0; m_seg = '0; m_cyc = '0; m_sv = 1'b0; m_drop = 1'b0;
        m_q.delete();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] a;
            int         pick;
            logic       was_full, sv0;
            pick = $urandom_range(0, 8);
            a = (pick == 8) ? 8'($urandom) : addr_tbl[pick];
            bus.io_addr   = a;
            bus.io_we     = ($urandom_range(0, 3) == 0);
            bus.io_rd     = 1'($urandom_range(0, 1));
            bus.io_dout   = $urandom;
            bus.seg_ready = 1'($urandom_range(0, 1));
            bus.sw_valid  = (n < 200) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 1);
            bus.sw_data   = $urandom;
            #1;
            chk($sformatf("r%0d_din", n), bus.io_din, model_din(a));
            chk($sformatf("r%0d_sw_ready", n), bus.sw_ready, 32'(m_q.size() < DEPTH));
            chk($sformatf("r%0d_seg_valid", n), bus.seg_valid, 32'(m_sv));
            chk($sformatf("r%0d_led", n), bus.led, m_led);
            chk($sformatf("r%0d_seg_data", n), bus.seg_data, m_seg);

            was_full = (m_q.size() == DEPTH);
            sv0      = m_sv;
            if (bus.io_we && a == 8'h00) m_led = bus.io_dout;
            if (bus.io_we && a == 8'h08) begin
                if (sv0 && !bus.seg_ready) m_drop = 1'b1;
                else begin
                    m_seg = bus.io_dout;
                    m_sv  = 1'b1;
                end
            end else if (sv0 && bus.seg_ready) begin
                m_sv = 1'b0;
            end
            if (bus.io_rd && a == 8'h10) m_drop = 1'b0;
            if (bus.io_rd && a == 8'h0C && m_q.size() != 0) void'(m_q.pop_front());
            if (bus.sw_valid && !was_full) m_q.push_back(bus.sw_data);
            if (bus.io_we && a == 8'h14) m_cyc = bus.io_dout;
            else m_cyc = m_cyc + 32'd1;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
